// File: rtl/car_pkg.sv
// rtl/car_pkg.sv - shared command bit indices and arbiter state type
package car_pkg;

  localparam int CMD_W       = 6;
  localparam int CMD_FWD     = 5;
  localparam int CMD_BWD     = 4;
  localparam int CMD_LEFT    = 3;
  localparam int CMD_RIGHT   = 2;
  localparam int CMD_PLACE   = 1;
  localparam int CMD_DESTROY = 0;

  typedef enum logic {
    ST_ACTIVE,
    ST_GUARD
  } state_t;

endpackage

// File: rtl/pulse_cooldown.sv
// rtl/pulse_cooldown.sv - rising-edge one-shot with a post-pulse cooldown window
module pulse_cooldown #(
  parameter int COOLDOWN = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic load,
  input  logic load_val,
  input  logic req,
  input  logic block,
  output logic rise,
  output logic pulse
);

  localparam int CW = $clog2(COOLDOWN + 1);
  localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN);

  logic          prev;
  logic [CW-1:0] cd;
  logic          fire;

  assign rise = en & req & ~prev;
  // Edges arriving during cooldown are simply lost; nothing is queued.
  assign fire = rise & ~block & (cd == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev  <= 1'b0;
      cd    <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= fire;
      if (load) begin
        prev <= load_val;
      end else if (en) begin
        prev <= req;
      end
      if (fire) begin
        cd <= CD_LOAD;
      end else if (cd != '0) begin
        cd <= cd - 1'b1;
      end
    end
  end

endmodule

// File: rtl/drive_cmd_arbiter.sv
// rtl/drive_cmd_arbiter.sv - guarded N:1 drive-command selector with reversal gap,
// opposing-command interlock and barrier one-shots
module drive_cmd_arbiter
  import car_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int SEL_W        = $clog2(NUM_SRC),
  parameter int GUARD_CYCLES = 8,
  parameter int REV_GAP      = 4,
  parameter int BARRIER_CD   = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_SRC*CMD_W-1:0] in_cmd,
  output logic                     move_forward,
  output logic                     move_backward,
  output logic                     turn_left,
  output logic                     turn_right,
  output logic                     place_barrier,
  output logic                     destroy_barrier,
  output logic [SEL_W-1:0]         active_src,
  output logic                     switching,
  output logic                     conflict
);

  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam int RW = $clog2(REV_GAP + 1);
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES - 1);
  localparam logic [RW-1:0] REV_LOAD   = RW'(REV_GAP);

  state_t           state, next_state;
  logic [SEL_W-1:0] pending, next_pending, next_active, src;
  logic [GW-1:0]    guard_cnt, next_gcnt;
  logic [RW-1:0]    rev_cnt;
  logic             last_bwd;
  logic             stay, exit_guard, drive;
  logic [CMD_W-1:0] bundle;
  logic             req_f, req_b, req_l, req_r;
  logic             fb_clash, lr_clash, rev_hold;
  logic             f_pass, b_pass, l_pass, r_pass;
  logic             place_rise, destroy_rise, place_out, destroy_out;

  always_comb begin
    next_state   = state;
    next_pending = pending;
    next_gcnt    = guard_cnt;
    next_active  = active_src;
    stay         = 1'b0;
    exit_guard   = 1'b0;
    src          = active_src;
    case (state)
      ST_ACTIVE: begin
        if (sel == active_src) begin
          stay = 1'b1;
        end else begin
          next_state   = ST_GUARD;
          next_pending = sel;
          next_gcnt    = GUARD_LOAD;
        end
      end
      ST_GUARD: begin
        if (sel != pending) begin
          next_pending = sel;
          next_gcnt    = GUARD_LOAD;
        end else if (guard_cnt == '0) begin
          next_state  = ST_ACTIVE;
          next_active = pending;
          exit_guard  = 1'b1;
          src         = pending;
        end else begin
          next_gcnt = guard_cnt - 1'b1;
        end
      end
      default: next_state = ST_ACTIVE;
    endcase
  end

  // Out-of-range indices act as a null source with an all-zero bundle.
  always_comb begin
    bundle = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (src == SEL_W'(k)) bundle = in_cmd[k*CMD_W +: CMD_W];
    end
  end

  assign drive    = stay | exit_guard;
  assign req_f    = drive & bundle[CMD_FWD];
  assign req_b    = drive & bundle[CMD_BWD];
  assign req_l    = drive & bundle[CMD_LEFT];
  assign req_r    = drive & bundle[CMD_RIGHT];
  assign fb_clash = req_f & req_b;
  assign lr_clash = req_l & req_r;

  // rev_cnt counts the idle cycle in progress, so the opposite direction may
  // assert on the edge where the count is down to 1.
  assign rev_hold = rev_cnt > RW'(1);
  assign f_pass   = req_f & ~fb_clash & ~(last_bwd & (move_backward | rev_hold));
  assign b_pass   = req_b & ~fb_clash & ~(~last_bwd & (move_forward | rev_hold));
  assign l_pass   = req_l & ~lr_clash;
  assign r_pass   = req_r & ~lr_clash;

  pulse_cooldown #(.COOLDOWN(BARRIER_CD)) u_place (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (stay),
    .load     (exit_guard),
    .load_val (bundle[CMD_PLACE]),
    .req      (bundle[CMD_PLACE]),
    .block    (destroy_rise),
    .rise     (place_rise),
    .pulse    (place_out)
  );

  pulse_cooldown #(.COOLDOWN(BARRIER_CD)) u_destroy (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (stay),
    .load     (exit_guard),
    .load_val (bundle[CMD_DESTROY]),
    .req      (bundle[CMD_DESTROY]),
    .block    (place_rise),
    .rise     (destroy_rise),
    .pulse    (destroy_out)
  );

  assign place_barrier   = place_out;
  assign destroy_barrier = destroy_out;
  assign switching       = (state == ST_GUARD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_ACTIVE;
      pending       <= '0;
      guard_cnt     <= '0;
      active_src    <= '0;
      rev_cnt       <= '0;
      last_bwd      <= 1'b0;
      move_forward  <= 1'b0;
      move_backward <= 1'b0;
      turn_left     <= 1'b0;
      turn_right    <= 1'b0;
      conflict      <= 1'b0;
    end else begin
      state         <= next_state;
      pending       <= next_pending;
      guard_cnt     <= next_gcnt;
      active_src    <= next_active;
      move_forward  <= f_pass;
      move_backward <= b_pass;
      turn_left     <= l_pass;
      turn_right    <= r_pass;
      conflict      <= fb_clash | lr_clash | (place_rise & destroy_rise);
      if ((move_forward & ~f_pass) | (move_backward & ~b_pass)) begin
        rev_cnt <= REV_LOAD;
      end else if (rev_cnt != '0) begin
        rev_cnt <= rev_cnt - 1'b1;
      end
      if (f_pass) begin
        last_bwd <= 1'b0;
      end else if (b_pass) begin
        last_bwd <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// tb/tb_drive_cmd_arbiter.sv - directed and randomized bench for drive_cmd_arbiter
module tb_drive_cmd_arbiter;

  localparam int NUM_SRC = 5;
  localparam int SEL_W   = 3;
  localparam int GUARD   = 8;
  localparam int REV     = 4;
  localparam int CD      = 16;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic [SEL_W-1:0]       sel = '0;
  logic [NUM_SRC*6-1:0]   in_cmd = '0;
  logic                   move_forward, move_backward, turn_left, turn_right;
  logic                   place_barrier, destroy_barrier, switching, conflict;
  logic [SEL_W-1:0]       active_src;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  drive_cmd_arbiter #(
    .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .GUARD_CYCLES(GUARD),
    .REV_GAP(REV), .BARRIER_CD(CD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sel(sel), .in_cmd(in_cmd),
    .move_forward(move_forward), .move_backward(move_backward),
    .turn_left(turn_left), .turn_right(turn_right),
    .place_barrier(place_barrier), .destroy_barrier(destroy_barrier),
    .active_src(active_src), .switching(switching), .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] bun(input int s);
    if (s < NUM_SRC) return in_cmd[s*6 +: 6];
    return 6'd0;
  endfunction

  // Reference model: edge-numbered timestamps for the reversal gap and cooldown.
  bit m_guard, m_mf, m_mb, m_tl, m_tr, m_pl, m_de, m_cf;
  int m_act, m_pend, m_gleft, edge_no, fall_edge, lastp, lastd;
  bit fall_bwd, prevp, prevd;
  int s;
  bit stay, exitg, f, b, l, r, rp, rd;
  logic [5:0] bb;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_guard = 0; m_act = 0; m_pend = 0; m_gleft = 0; edge_no = 0;
      {m_mf, m_mb, m_tl, m_tr, m_pl, m_de, m_cf} = '0;
      fall_edge = -1000; fall_bwd = 0; prevp = 0; prevd = 0;
      lastp = -1000; lastd = -1000;
    end else begin
      edge_no++;
      s = int'(sel); stay = 0; exitg = 0;
      if (!m_guard) begin
        if (s == m_act) stay = 1;
        else begin m_guard = 1; m_pend = s; m_gleft = GUARD - 1; end
      end else if (s != m_pend) begin
        m_pend = s; m_gleft = GUARD - 1;
      end else if (m_gleft == 0) begin
        m_guard = 0; m_act = m_pend; exitg = 1;
      end else begin
        m_gleft--;
      end
      bb = (stay || exitg) ? bun(m_act) : 6'd0;
      f = bb[5]; b = bb[4]; l = bb[3]; r = bb[2]; m_cf = 0;
      if (f && b) begin f = 0; b = 0; m_cf = 1; end
      if (l && r) begin l = 0; r = 0; m_cf = 1; end
      if (f && (m_mb || (fall_bwd && edge_no - fall_edge < REV))) f = 0;
      if (b && (m_mf || (!fall_bwd && edge_no - fall_edge < REV))) b = 0;
      if (m_mf && !f) begin fall_edge = edge_no; fall_bwd = 0; end
      if (m_mb && !b) begin fall_edge = edge_no; fall_bwd = 1; end
      rp = stay && bb[1] && !prevp;
      rd = stay && bb[0] && !prevd;
      m_pl = 0; m_de = 0;
      if (rp && rd) m_cf = 1;
      else begin
        if (rp && edge_no - lastp > CD) begin m_pl = 1; lastp = edge_no; end
        if (rd && edge_no - lastd > CD) begin m_de = 1; lastd = edge_no; end
      end
      if (stay || exitg) begin prevp = bb[1]; prevd = bb[0]; end
      m_mf = f; m_mb = b; m_tl = l; m_tr = r;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("mdl_fwd", move_forward, m_mf);
      check("mdl_bwd", move_backward, m_mb);
      check("mdl_left", turn_left, m_tl);
      check("mdl_right", turn_right, m_tr);
      check("mdl_place", place_barrier, m_pl);
      check("mdl_destroy", destroy_barrier, m_de);
      check("mdl_conflict", conflict, m_cf);
      check("mdl_switching", switching, m_guard);
      check("mdl_active", active_src, m_guard ? m_act : m_act);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_src(input int k, input logic [5:0] v);
    in_cmd[k*6 +: 6] = v;
  endtask

  int cnt, last_p, min_sp;
  bit p;

  initial begin
    set_src(0, 6'b100000);
    tick(3);
    chk_on = 1;
    check("rst_fwd", move_forward, 0);
    check("rst_active", active_src, 0);
    reset_n = 1;
    tick(1);
    check("fwd_after_reset", move_forward, 1);
    check("active0", active_src, 0);

    // Switch 0 -> 2: eight guard cycles, then source 2 drives.
    set_src(2, 6'b100000);
    sel = 3'd2;
    for (int i = 0; i < GUARD; i++) begin
      tick(1);
      check("guard_sw", switching, 1);
      check("guard_fwd", move_forward, 0);
    end
    tick(1);
    check("post_guard_fwd", move_forward, 1);
    check("post_guard_src", active_src, 2);
    check("post_guard_sw", switching, 0);

    // Re-selecting mid-guard restarts the full guard.
    sel = 3'd0;
    tick(5);
    set_src(3, 6'b100000);
    sel = 3'd3;
    for (int i = 0; i < GUARD; i++) begin
      tick(1);
      check("restart_sw", switching, 1);
    end
    tick(1);
    check("restart_src", active_src, 3);
    check("restart_fwd", move_forward, 1);

    // Reversal gap.
    tick(2);
    set_src(3, 6'b010000);
    tick(1);
    check("rev_fwd_fall", move_forward, 0);
    for (int i = 0; i < REV; i++) begin
      check("rev_hold", move_backward, 0);
      tick(1);
    end
    check("rev_bwd", move_backward, 1);

    // Interlock.
    set_src(3, 6'b110000);
    tick(1);
    check("fb_fwd", move_forward, 0);
    check("fb_bwd", move_backward, 0);
    check("fb_conflict", conflict, 1);
    set_src(3, 6'b001100);
    tick(1);
    check("lr_left", turn_left, 0);
    check("lr_right", turn_right, 0);
    check("lr_conflict", conflict, 1);
    set_src(3, 6'b001000);
    tick(1);
    check("left_pass", turn_left, 1);
    check("left_noconf", conflict, 0);

    // Barrier: held level gives one pulse.
    set_src(3, 6'b000000);
    tick(20);
    set_src(3, 6'b000010);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (place_barrier) cnt++;
    end
    check("held_place_pulses", cnt, 1);

    // Toggled request: pulses spaced by the cooldown.
    p = 1; cnt = 0; last_p = -1000; min_sp = 1000;
    for (int i = 0; i < 60; i++) begin
      if (i % 2 == 0) p = ~p;
      set_src(3, {4'b0000, p, 1'b0});
      tick(1);
      if (place_barrier) begin
        if (i - last_p < min_sp) min_sp = i - last_p;
        last_p = i; cnt++;
      end
    end
    check("toggle_pulses_ge2", int'(cnt >= 2), 1);
    check("toggle_spacing_ge16", int'(min_sp >= 16), 1);

    // Simultaneous place/destroy rise.
    set_src(3, 6'b000000);
    tick(20);
    set_src(3, 6'b000011);
    tick(1);
    check("pd_place", place_barrier, 0);
    check("pd_destroy", destroy_barrier, 0);
    check("pd_conflict", conflict, 1);

    // New source already holding place: no pulse after the switch.
    set_src(3, 6'b000000);
    tick(20);
    set_src(1, 6'b000010);
    sel = 3'd1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (place_barrier) cnt++;
    end
    check("switch_no_pulse", cnt, 0);

    // Null source.
    sel = 3'd5;
    tick(GUARD + 1);
    check("null_src", active_src, 5);
    check("null_fwd", move_forward, 0);
    check("null_sw", switching, 0);

    // Reset in the middle of a guard.
    sel = 3'd0;
    tick(3);
    check("pre_reset_sw", switching, 1);
    @(posedge clk);
    #2 reset_n = 0;
    #1;
    check("mid_reset_sw", switching, 0);
    check("mid_reset_src", active_src, 0);
    check("mid_reset_fwd", move_forward, 0);
    @(negedge clk);
    reset_n = 1;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        @(posedge clk);
        #2 reset_n = 0;
        @(posedge clk);
        #2 reset_n = 1;
      end
      @(negedge clk);
      if ($urandom_range(0, 29) == 0) sel = SEL_W'($urandom_range(0, 7));
      for (int k = 0; k < NUM_SRC; k++) begin
        if ($urandom_range(0, 5) == 0) set_src(k, 6'($urandom));
      end
    end
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
